// File: rtl/sb_pattern_detector_param_if.sv
// Sideband RX stream bundle between the deserialiser/decoder side and the
// pattern detector.
//   i_de_ser_data / i_de_ser_valid : deserialised word and its qualifier
//   i_out_ready                    : decoder can take the forwarded word
//   o_pattern_out / o_pattern_out_valid : forwarded word, held until accepted
// master: the surrounding logic (drives words and ready, observes forwarding)
// slave : the pattern detector
interface sb_pattern_detector_param_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] i_de_ser_data;
    logic              i_de_ser_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_pattern_out;
    logic              o_pattern_out_valid;

    modport master (
        output i_de_ser_data,
        output i_de_ser_valid,
        output i_out_ready,
        input  o_pattern_out,
        input  o_pattern_out_valid
    );

    modport slave (
        input  i_de_ser_data,
        input  i_de_ser_valid,
        input  i_out_ready,
        output o_pattern_out,
        output o_pattern_out_valid
    );
endinterface

// File: rtl/sb_pattern_detector_param.sv
// Sideband RX pattern detector. Hunts for runs of alternating clock-pattern
// words during RESET and SBINIT, pulses start-of-pattern / sample-done to the
// link training FSM, flags SBINIT timeout, and forwards non-pattern words to
// the message decoder through a 1-entry valid/ready register.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_state                      : 0 RESET, 1 SBINIT, others ACTIVE
//   sb (slave)                   : word input and forwarded-word output
//   o_rx_sb_start_pattern        : pulse, first match seen in RESET
//   o_rx_sb_pattern_samp_done    : pulse, REQ_CNT consecutive matches in SBINIT
//   o_timeout                    : pulse, TIMEOUT_CYC SBINIT cycles w/o done
//   o_overflow                   : pulse, forwarded word dropped (reg full)
module sb_pattern_detector_param #(
    parameter int DATA_W      = 64,
    parameter int REQ_CNT     = 2,
    parameter int MSB_VAL     = 1,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_W        = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [2:0]                 i_state,
    sb_pattern_detector_param_if.slave sb,
    output logic                       o_rx_sb_start_pattern,
    output logic                       o_rx_sb_pattern_samp_done,
    output logic                       o_timeout,
    output logic                       o_overflow
);
    localparam int               CNT_W     = $clog2(REQ_CNT + 1);
    localparam logic [CNT_W-1:0] REQ_V     = CNT_W'(REQ_CNT);
    localparam logic [TO_W-1:0]  TO_V      = TO_W'(TIMEOUT_CYC);
    localparam logic [2:0]       ST_RESET  = 3'd0;
    localparam logic [2:0]       ST_SBINIT = 3'd1;

    // A clock-pattern word alternates on every bit and ends in MSB_VAL.
    function automatic logic is_pattern(input logic [DATA_W-1:0] w);
        logic ok;
        ok = (w[DATA_W-1] == (MSB_VAL != 0));
        for (int k = 0; k < DATA_W - 1; k++) begin
            if (w[k] == w[k+1]) ok = 1'b0;
        end
        return ok;
    endfunction

    // In ACTIVE states the run length has no consumer; saturate so it
    // cannot wrap inside its narrow counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= REQ_V) ? REQ_V : c + CNT_W'(1);
    endfunction

    logic [2:0]        state_prev_q, state_prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              to_q, to_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;

    logic              state_chg, in_reset, in_sbinit, match, fwd;
    logic [CNT_W-1:0]  cnt_base, cnt_next;

    always_comb begin
        state_chg    = (i_state != state_prev_q);
        in_reset     = (i_state == ST_RESET);
        in_sbinit    = (i_state == ST_SBINIT);
        match        = is_pattern(sb.i_de_ser_data);
        // A state change restarts the run before this cycle's word counts.
        cnt_base     = state_chg ? '0 : cnt_q;
        cnt_next     = cnt_base + CNT_W'(1);

        state_prev_d = i_state;
        cnt_d        = cnt_base;
        start_d      = 1'b0;
        done_d       = 1'b0;
        fwd          = 1'b0;

        if (sb.i_de_ser_valid) begin
            if (match) begin
                if (in_reset) begin
                    start_d = (cnt_base == '0);
                    cnt_d   = (cnt_next == REQ_V) ? '0 : cnt_next;
                end else if (in_sbinit) begin
                    if (cnt_next == REQ_V) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d  = cnt_next;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_base);
                    fwd   = 1'b1;
                end
            end else begin
                cnt_d = '0;
                fwd   = !in_reset;
            end
        end

        // SBINIT watchdog: restarts on entry and on every sample-done.
        tcnt_d = '0;
        to_d   = 1'b0;
        if ((TIMEOUT_CYC != 0) && in_sbinit && !state_chg && !done_d) begin
            if (tcnt_q + TO_W'(1) == TO_V) begin
                to_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TO_W'(1);
            end
        end

        // 1-entry output register: load when empty or being drained this
        // cycle; otherwise the incoming word is lost and reported.
        data_d = data_q;
        vld_d  = vld_q;
        ovf_d  = 1'b0;
        if (fwd) begin
            if (!vld_q || sb.i_out_ready) begin
                data_d = sb.i_de_ser_data;
                vld_d  = 1'b1;
            end else begin
                ovf_d  = 1'b1;
            end
        end else if (vld_q && sb.i_out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_prev_q <= ST_RESET;
            cnt_q        <= '0;
            tcnt_q       <= '0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            to_q         <= 1'b0;
            ovf_q        <= 1'b0;
            data_q       <= '0;
            vld_q        <= 1'b0;
        end else begin
            state_prev_q <= state_prev_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            start_q      <= start_d;
            done_q       <= done_d;
            to_q         <= to_d;
            ovf_q        <= ovf_d;
            data_q       <= data_d;
            vld_q        <= vld_d;
        end
    end

    assign o_rx_sb_start_pattern     = start_q;
    assign o_rx_sb_pattern_samp_done = done_q;
    assign o_timeout                 = to_q;
    assign o_overflow                = ovf_q;
    assign sb.o_pattern_out          = data_q;
    assign sb.o_pattern_out_valid    = vld_q;
endmodule

// File: doc/sb_pattern_detector_param.md
Name: sb_pattern_detector_param

Overview:
Parametrised sideband RX pattern detector placed between the SB deserialiser and the SB message decoder.
- Hunts for N consecutive clock-pattern words during link RESET and SBINIT.
- Reports start-of-pattern and sample-done pulses to the link training FSM.
- Flags SBINIT timeout.
- Forwards non-pattern words to the decoder through a 1-entry valid/ready output register with overflow reporting.

Parameters:
DATA_W, 64, deserialised word width (>=2).
REQ_CNT, 2, consecutive matching words required for sample-done (>=1).
MSB_VAL, 1, required value of data[DATA_W-1] in a matching word.
TIMEOUT_CYC, 1000, SBINIT cycles without sample-done before timeout; 0 disables.
TO_W, 16, timeout counter width (2^TO_W > TIMEOUT_CYC).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_de_ser_data  in  DATA_W  deserialised word
i_de_ser_valid  in  1  word valid (single-cycle qualifier)
i_state  in  3  link state: 0 RESET, 1 SBINIT, others ACTIVE
i_out_ready  in  1  decoder can accept o_pattern_out
o_rx_sb_start_pattern  out  1  pulse: first match in RESET
o_rx_sb_pattern_samp_done  out  1  pulse: REQ_CNT consecutive matches in SBINIT
o_timeout  out  1  pulse: SBINIT timeout
o_pattern_out  out  DATA_W  forwarded word
o_pattern_out_valid  out  1  forwarded word valid, held until accepted
o_overflow  out  1  pulse: forwarded word dropped

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst. When i_rst=1 at a rising edge, every output, the match counter and the timeout counter go to 0. i_rst overrides all other activity, including a held output word.
- Match definition: data[k] != data[k+1] for all k in 0..DATA_W-2, and data[DATA_W-1] == MSB_VAL. Evaluation is purely combinational; every registered output has 1-cycle latency.
- Match counter (width clog2(REQ_CNT+1)):
  - Increments on a valid matching word.
  - Clears on a valid non-matching word, so matches must be consecutive.
  - Clears on any cycle where i_state differs from its previous-cycle value.
  - Invalid cycles do not change it.
- RESET state:
  - Valid match with counter==0: o_rx_sb_start_pattern pulses for 1 cycle.
  - When the counter reaches REQ_CNT it clears to 0; no samp_done.
  - Non-matching words are dropped, not forwarded.
  - If REQ_CNT==1, the start pulse still fires on every match.
- SBINIT state:
  - Valid match bringing the counter to REQ_CNT: o_rx_sb_pattern_samp_done pulses; counter clears.
  - Valid non-matching word: forwarded.
  - Matching words are never forwarded.
- ACTIVE states: every valid word is forwarded unchanged; detection outputs stay 0.
- Timeout:
  - Counts every cycle in SBINIT, reloading to 0 on SBINIT entry and on samp_done.
  - Reaching TIMEOUT_CYC: o_timeout pulses 1 cycle and the counter reloads.
  - Held at 0 outside SBINIT. Inactive when TIMEOUT_CYC==0.
- Output register:
  - Forward with register empty, or with o_pattern_out_valid && i_out_ready: register loads the word and valid=1 next cycle (full throughput).
  - Forward while valid && !i_out_ready: new word dropped, stored word held, o_overflow pulses.
  - Accept with no forward: valid=0; o_pattern_out retains its value.
  - o_pattern_out and o_pattern_out_valid must not change while valid && !ready.
- State change while a word is held: the word stays held until accepted.

Test Plan:
- Reset: assert i_rst 2 cycles with random inputs -> all outputs 0; deassert with no valid input -> outputs remain 0.
- i_state=0; send 64'hAAAA_AAAA_AAAA_AAAA twice -> o_rx_sb_start_pattern=1 exactly one cycle after the first word, none after the second; no forwarding.
- i_state=1, i_out_ready=1; send AAAA..., then 64'h1234, then AAAA..., AAAA... -> 64'h1234 forwarded with valid 1 cycle after input; samp_done pulses only after the fourth word (counter reset by the mismatch).
- i_state=2, i_out_ready=0; send words 0x11 then 0x22 -> o_pattern_out=0x11 held, o_overflow pulses 1 cycle after 0x22; raise ready -> valid drops next cycle.
- i_state=1, TIMEOUT_CYC=1000, no valid input -> o_timeout pulses at cycle 1000 after entry and again at 2000; a samp_done at cycle 500 delays the next pulse to cycle 1500.
- i_state=1 with 1 match counted, i_state toggled 1->2->1, then 1 more match -> no samp_done (counter cleared by the state change).
